// File: rtl/disp_pixbuf.sv
// Pixel buffer: a 64-bit word FIFO unpacked into a 24-bit RGB stream through a two-stage read pipeline.
// Define DISP_PIXBUF_BLANK_EN to drive DSP_R/G/B to zero whenever DSP_DE is low; otherwise they hold the last pixel.
module disp_pixbuf #(
  parameter int DEPTH        = 512,
  parameter int PIX_PER_WORD = 2,
  parameter int WR_SLACK     = 16
) (
  input  logic                     ACLK,
  input  logic                     ARST,
  input  logic                     DISPON,
  input  logic                     FIFORST,
  input  logic [63:0]              FIFOIN,
  input  logic                     FIFOWR,
  input  logic                     DSP_preDE,
  output logic                     BUF_WREADY,
  output logic                     BUF_OVER,
  output logic                     BUF_UNDER,
  output logic [$clog2(DEPTH):0]   BUF_LEVEL,
  output logic [7:0]               DSP_R,
  output logic [7:0]               DSP_G,
  output logic [7:0]               DSP_B,
  output logic                     DSP_DE
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Only the two 24-bit pixel fields are kept, so the RAM is 48 bits wide.
  logic [47:0]   mem [DEPTH];
  logic [47:0]   rd_word;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          half;
  logic          de_s1;
  logic          under_s1;
  logic          half_s1;

  logic          full;
  logic          empty;
  logic          req;
  logic          last_pix;
  logic          push;
  logic          pop;
  logic [LW-1:0] level_next;
  logic          wready_next;
  logic [23:0]   pix_sel;
  logic          unused_in;

  assign unused_in = ^{FIFOIN[63:56], FIFOIN[31:24]};

  always_comb begin
    full        = (BUF_LEVEL == LW'(DEPTH));
    empty       = (BUF_LEVEL == '0);
    req         = DISPON && DSP_preDE && !FIFORST;
    last_pix    = (PIX_PER_WORD == 1) || half;
    push        = FIFOWR && !full && !FIFORST;
    pop         = req && !empty && last_pix;
    level_next  = FIFORST ? '0 : (BUF_LEVEL + LW'(push) - LW'(pop));
    wready_next = (DEPTH - int'(level_next)) >= WR_SLACK;
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= {FIFOIN[55:32], FIFOIN[23:0]};
    end
    rd_word <= mem[rd_ptr];
  end

  // Full/empty are judged on the registered level, so a same-edge read never makes room for a write.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      half       <= 1'b0;
      BUF_LEVEL  <= '0;
      BUF_WREADY <= 1'b0;
      BUF_OVER   <= 1'b0;
      BUF_UNDER  <= 1'b0;
      de_s1      <= 1'b0;
      under_s1   <= 1'b0;
      half_s1    <= 1'b0;
    end else if (FIFORST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      half       <= 1'b0;
      BUF_LEVEL  <= '0;
      BUF_WREADY <= wready_next;
      BUF_OVER   <= 1'b0;
      BUF_UNDER  <= 1'b0;
      de_s1      <= 1'b0;
      under_s1   <= 1'b0;
      half_s1    <= 1'b0;
    end else begin
      BUF_LEVEL  <= level_next;
      BUF_WREADY <= wready_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (FIFOWR && full) begin
        BUF_OVER <= 1'b1;
      end
      if (req && empty) begin
        BUF_UNDER <= 1'b1;
      end
      if (req && !empty) begin
        if (last_pix) begin
          rd_ptr <= rd_ptr + 1'b1;
          half   <= 1'b0;
        end else begin
          half   <= 1'b1;
        end
      end
      de_s1    <= req;
      under_s1 <= empty;
      half_s1  <= half;
    end
  end

  always_comb begin
    pix_sel = (PIX_PER_WORD == 2 && half_s1) ? rd_word[47:24] : rd_word[23:0];
  end

  // Underflowed requests still produce a valid (black) pixel so line timing is preserved.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      DSP_DE                <= 1'b0;
      {DSP_R, DSP_G, DSP_B} <= '0;
    end else if (FIFORST) begin
      DSP_DE <= 1'b0;
`ifdef DISP_PIXBUF_BLANK_EN
      {DSP_R, DSP_G, DSP_B} <= '0;
`endif
    end else begin
      DSP_DE <= de_s1;
      if (de_s1) begin
        {DSP_R, DSP_G, DSP_B} <= under_s1 ? 24'h000000 : pix_sel;
      end
`ifdef DISP_PIXBUF_BLANK_EN
      else begin
        {DSP_R, DSP_G, DSP_B} <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_disp_pixbuf.sv
// Directed bench for disp_pixbuf with DEPTH=16, PIX_PER_WORD=2, WR_SLACK=4.
// Idle-pixel expectations follow DISP_PIXBUF_BLANK_EN.
module tb_disp_pixbuf;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b0;
  logic        DISPON = 1'b0;
  logic        FIFORST = 1'b0;
  logic [63:0] FIFOIN = 64'h0;
  logic        FIFOWR = 1'b0;
  logic        DSP_preDE = 1'b0;
  logic        BUF_WREADY;
  logic        BUF_OVER;
  logic        BUF_UNDER;
  logic [4:0]  BUF_LEVEL;
  logic [7:0]  DSP_R;
  logic [7:0]  DSP_G;
  logic [7:0]  DSP_B;
  logic        DSP_DE;
  logic [23:0] pix;

  int checks = 0;
  int errors = 0;

`ifdef DISP_PIXBUF_BLANK_EN
  localparam logic [31:0] IDLE_A = 32'h000000;
  localparam logic [31:0] IDLE_B = 32'h000000;
`else
  localparam logic [31:0] IDLE_A = 32'hAABBCC;
  localparam logic [31:0] IDLE_B = 32'h123456;
`endif

  disp_pixbuf #(.DEPTH(16), .PIX_PER_WORD(2), .WR_SLACK(4)) dut (
    .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .FIFORST(FIFORST),
    .FIFOIN(FIFOIN), .FIFOWR(FIFOWR), .DSP_preDE(DSP_preDE),
    .BUF_WREADY(BUF_WREADY), .BUF_OVER(BUF_OVER), .BUF_UNDER(BUF_UNDER),
    .BUF_LEVEL(BUF_LEVEL), .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
    .DSP_DE(DSP_DE)
  );

  assign pix = {DSP_R, DSP_G, DSP_B};

  always #5 ACLK = ~ACLK;

  function automatic logic [63:0] word(input int i);
    return {8'h00, 24'hA00000 + 24'(i), 8'h00, 24'hB00000 + 24'(i)};
  endfunction

  task automatic applyStimulus(input logic dispon, input logic fiforst, input logic fifowr,
                               input logic [63:0] din, input logic prede);
    DISPON    = dispon;
    FIFORST   = fiforst;
    FIFOWR    = fifowr;
    FIFOIN    = din;
    DSP_preDE = prede;
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] exp_pix;
    int          idx;

    $display("[TB] reset");
    #1 ARST = 1'b1;
    #1;
    checkOutput("rst_level", 32'(BUF_LEVEL), 0);
    checkOutput("rst_wready", 32'(BUF_WREADY), 0);
    checkOutput("rst_over", 32'(BUF_OVER), 0);
    checkOutput("rst_under", 32'(BUF_UNDER), 0);
    checkOutput("rst_de", 32'(DSP_DE), 0);
    checkOutput("rst_pix", 32'(pix), 0);
    @(posedge ACLK);
    #1;
    ARST = 1'b0;
    checkOutput("wready_held", 32'(BUF_WREADY), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("wready_rise", 32'(BUF_WREADY), 1);

    $display("[TB] basic two-pixel word");
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h00AABBCC_00112233, 1'b0);
    checkOutput("a_level1", 32'(BUF_LEVEL), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("a_de_lat", 32'(DSP_DE), 0);
    checkOutput("a_level_hold", 32'(BUF_LEVEL), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("a_de0", 32'(DSP_DE), 1);
    checkOutput("a_pix0", 32'(pix), 32'h112233);
    checkOutput("a_level0", 32'(BUF_LEVEL), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("a_de1", 32'(DSP_DE), 1);
    checkOutput("a_pix1", 32'(pix), 32'hAABBCC);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("a_de_off", 32'(DSP_DE), 0);
    checkOutput("a_pix_idle", 32'(pix), IDLE_A);

    $display("[TB] underflow");
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("u_flag", 32'(BUF_UNDER), 1);
    checkOutput("u_de_lat", 32'(DSP_DE), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("u_de0", 32'(DSP_DE), 1);
    checkOutput("u_pix0", 32'(pix), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("u_de1", 32'(DSP_DE), 1);
    checkOutput("u_pix1", 32'(pix), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("u_de2", 32'(DSP_DE), 1);
    checkOutput("u_pix2", 32'(pix), 0);
    checkOutput("u_level", 32'(BUF_LEVEL), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("u_de_off", 32'(DSP_DE), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("u_clear", 32'(BUF_UNDER), 0);

    $display("[TB] write slack and overflow");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, word(i), 1'b0);
      if (i == 11) begin
        checkOutput("s_level12", 32'(BUF_LEVEL), 12);
        checkOutput("s_wready12", 32'(BUF_WREADY), 1);
      end
    end
    checkOutput("s_level13", 32'(BUF_LEVEL), 13);
    checkOutput("s_wready13", 32'(BUF_WREADY), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("s_level_halfread", 32'(BUF_LEVEL), 13);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("s_level_pop", 32'(BUF_LEVEL), 12);
    checkOutput("s_wready_pop", 32'(BUF_WREADY), 1);
    checkOutput("s_pix_w0lo", 32'(pix), 32'hB00000);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("s_pix_w0hi", 32'(pix), 32'hA00000);
    for (int i = 13; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, word(i), 1'b0);
    end
    checkOutput("o_level_full", 32'(BUF_LEVEL), 16);
    checkOutput("o_over_pre", 32'(BUF_OVER), 0);
    checkOutput("o_wready_full", 32'(BUF_WREADY), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, word(17), 1'b0);
    checkOutput("o_level_drop", 32'(BUF_LEVEL), 16);
    checkOutput("o_over_set", 32'(BUF_OVER), 1);

    $display("[TB] drain across pointer wrap");
    for (int k = 0; k < 33; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, (k < 32));
      if (k >= 1) begin
        idx     = 1 + (k - 1) / 2;
        exp_pix = (((k - 1) % 2) == 0) ? (32'hB00000 + 32'(idx)) : (32'hA00000 + 32'(idx));
        checkOutput("d_de", 32'(DSP_DE), 1);
        checkOutput("d_pix", 32'(pix), exp_pix);
      end
    end
    checkOutput("d_level_empty", 32'(BUF_LEVEL), 0);
    checkOutput("d_under", 32'(BUF_UNDER), 0);
    checkOutput("d_over_sticky", 32'(BUF_OVER), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("d_de_off", 32'(DSP_DE), 0);

    $display("[TB] flush");
    for (int i = 20; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, word(i), 1'b0);
    end
    checkOutput("f_level5", 32'(BUF_LEVEL), 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, word(25), 1'b1);
    checkOutput("f_level", 32'(BUF_LEVEL), 0);
    checkOutput("f_over", 32'(BUF_OVER), 0);
    checkOutput("f_under", 32'(BUF_UNDER), 0);
    checkOutput("f_de", 32'(DSP_DE), 0);
    checkOutput("f_wready", 32'(BUF_WREADY), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("f_de_pipe", 32'(DSP_DE), 0);
    checkOutput("f_write_dropped", 32'(BUF_LEVEL), 0);

    $display("[TB] half-select restart and idle pixel");
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h00654321_00123456, 1'b0);
    checkOutput("b_level", 32'(BUF_LEVEL), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("b_de", 32'(DSP_DE), 1);
    checkOutput("b_pix", 32'(pix), 32'h123456);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("b_de_off", 32'(DSP_DE), 0);
    checkOutput("b_pix_idle", 32'(pix), IDLE_B);

    $display("[TB] display disabled");
    applyStimulus(1'b0, 1'b0, 1'b1, 64'h00777777_00ABCDEF, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("n_de", 32'(DSP_DE), 0);
    checkOutput("n_level", 32'(BUF_LEVEL), 2);
    checkOutput("n_under", 32'(BUF_UNDER), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("n_de2", 32'(DSP_DE), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("n_resume_de", 32'(DSP_DE), 1);
    checkOutput("n_resume_pix", 32'(pix), 32'h654321);
    checkOutput("n_resume_level", 32'(BUF_LEVEL), 1);

    $display("[TB] reset mid-line");
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("r_pix_before", 32'(pix), 32'hABCDEF);
    #3 ARST = 1'b1;
    #1;
    checkOutput("r_level", 32'(BUF_LEVEL), 0);
    checkOutput("r_wready", 32'(BUF_WREADY), 0);
    checkOutput("r_de", 32'(DSP_DE), 0);
    checkOutput("r_pix", 32'(pix), 0);
    #1 ARST = 1'b0;
    @(posedge ACLK);
    #1;
    checkOutput("r_wready_rise", 32'(BUF_WREADY), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h00111111_00222222, 1'b0);
    checkOutput("r_level1", 32'(BUF_LEVEL), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("r_restart_pix", 32'(pix), 32'h222222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
